// File: rtl/riscv_trace_buf_pkg.sv
// Shared debug definitions for the commit-trace buffer: FSM encodings and
// the widths of the fixed entry fields.
package riscv_trace_buf_pkg;

    typedef enum logic [1:0] {
        TRB_IDLE  = 2'd0,
        TRB_ARMED = 2'd1,
        TRB_POST  = 2'd2,
        TRB_DONE  = 2'd3
    } trb_state_t;

    localparam int TRB_PC_W = 32;
    localparam int TRB_WA_W = 5;

endpackage

// File: rtl/trace_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are intentionally not reset; read-during-write returns old data.
module trace_dp_ram #(
    parameter int AWIDTH = 6,
    parameter int WIDTH  = 69
) (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/riscv_trace_buf.sv
// Logic-analyser-style commit trace recorder: circular capture of write-back
// commits, PC-match / external trigger, post-trigger window, random-access readout.
module riscv_trace_buf
    import riscv_trace_buf_pkg::*;
#(
    parameter int AWIDTH    = 6,
    parameter int DWIDTH    = 32,
    parameter int POST_TRIG = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TR_EN,
    input  logic [31:0]       TR_PC,
    input  logic [4:0]        TR_WA,
    input  logic [DWIDTH-1:0] TR_WD,
    input  logic              ARM,
    input  logic              TRIG_PC_EN,
    input  logic [31:0]       TRIG_PC,
    input  logic              TRIG_EXT,
    input  logic              RD_REQ,
    input  logic [AWIDTH-1:0] RD_ADDR,
    output logic              RD_VALID,
    output logic [31:0]       RD_PC,
    output logic [4:0]        RD_WA,
    output logic [DWIDTH-1:0] RD_WD,
    output logic [1:0]        STATE,
    output logic              DONE,
    output logic              WRAPPED,
    output logic [AWIDTH-1:0] TRIG_IDX,
    output logic [AWIDTH:0]   COUNT
);

    localparam int EW = TRB_PC_W + TRB_WA_W + DWIDTH;
    localparam logic [AWIDTH:0] POST_TRIG_C = POST_TRIG[AWIDTH:0];

    trb_state_t        state, state_nxt;
    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH:0]   count;
    logic [AWIDTH:0]   post_cnt;
    logic              wrapped;
    logic [AWIDTH-1:0] trig_idx;
    logic              rd_valid_q, rd_zero_q;
    logic [EW-1:0]     ram_q;
    logic [AWIDTH-1:0] rd_phys;
    logic              capturing, wr, trig, post_hit, rd_live;

    // ARM wins over everything in its cycle, including a commit.
    assign capturing = (state == TRB_ARMED || state == TRB_POST) && !ARM;
    assign wr        = capturing && TR_EN;
    assign trig      = TRIG_EXT | (TR_EN & TRIG_PC_EN & (TR_PC == TRIG_PC));
    assign post_hit  = (state == TRB_POST) && wr && ((post_cnt + 1'b1) == POST_TRIG_C);

    always_comb begin
        state_nxt = state;
        if (ARM) begin
            state_nxt = TRB_ARMED;
        end else begin
            case (state)
                TRB_ARMED: if (trig) state_nxt = (POST_TRIG == 0) ? TRB_DONE : TRB_POST;
                TRB_POST:  if (post_hit) state_nxt = TRB_DONE;
                default:   state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= TRB_IDLE;
            wptr     <= '0;
            count    <= '0;
            post_cnt <= '0;
            wrapped  <= 1'b0;
            trig_idx <= '0;
        end else begin
            state <= state_nxt;
            if (ARM) begin
                wptr     <= '0;
                count    <= '0;
                post_cnt <= '0;
                wrapped  <= 1'b0;
                trig_idx <= '0;
            end else begin
                if (wr) begin
                    wptr <= wptr + 1'b1;
                    if (&wptr) wrapped <= 1'b1;
                    if (!count[AWIDTH]) count <= count + 1'b1;
                end
                // Pre-write pointer: the trigger entry itself, or the next one written.
                if (state == TRB_ARMED && trig) trig_idx <= wptr;
                if (state == TRB_POST && wr) post_cnt <= post_cnt + 1'b1;
            end
        end
    end

    // Logical index 0 is the oldest entry: once wrapped, that is the slot at wptr.
    assign rd_phys = (wrapped ? wptr : '0) + RD_ADDR;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b0;
        end else begin
            rd_valid_q <= RD_REQ;
            rd_zero_q  <= ({1'b0, RD_ADDR} >= count);
        end
    end

    trace_dp_ram #(
        .AWIDTH (AWIDTH),
        .WIDTH  (EW)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (wr),
        .wr_addr (wptr),
        .wr_data ({TR_PC, TR_WA, TR_WD}),
        .rd_en   (RD_REQ),
        .rd_addr (rd_phys),
        .rd_data (ram_q)
    );

    // RAM output is unreset, so data is masked by the reset-clean valid/zero flags.
    assign rd_live  = rd_valid_q && !rd_zero_q;
    assign RD_VALID = rd_valid_q;
    assign RD_PC    = rd_live ? ram_q[EW-1 -: TRB_PC_W] : '0;
    assign RD_WA    = rd_live ? ram_q[DWIDTH +: TRB_WA_W] : '0;
    assign RD_WD    = rd_live ? ram_q[DWIDTH-1:0] : '0;
    assign STATE    = state;
    assign DONE     = (state == TRB_DONE);
    assign WRAPPED  = wrapped;
    assign TRIG_IDX = trig_idx;
    assign COUNT    = count;

endmodule

// File: tb/tb_riscv_trace_buf.sv
// Directed bench for riscv_trace_buf: two 8-entry instances sharing stimulus,
// one with a 2-entry post-trigger window and one that stops on the trigger.
module tb_riscv_trace_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tr_en = 1'b0;
    logic [31:0] tr_pc = '0;
    logic [4:0]  tr_wa = '0;
    logic [31:0] tr_wd = '0;
    logic        arm = 1'b0;
    logic        trig_pc_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        trig_ext = 1'b0;
    logic        rd_req = 1'b0;
    logic [2:0]  rd_addr = '0;

    logic        a_rd_valid, b_rd_valid;
    logic [31:0] a_rd_pc, b_rd_pc;
    logic [4:0]  a_rd_wa, b_rd_wa;
    logic [31:0] a_rd_wd, b_rd_wd;
    logic [1:0]  a_state, b_state;
    logic        a_done, b_done, a_wrapped, b_wrapped;
    logic [2:0]  a_trig_idx, b_trig_idx;
    logic [3:0]  a_count, b_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_trace_buf #(.AWIDTH(3), .DWIDTH(32), .POST_TRIG(2)) u_a (
        .CLK(clk), .RST(rst), .TR_EN(tr_en), .TR_PC(tr_pc), .TR_WA(tr_wa), .TR_WD(tr_wd),
        .ARM(arm), .TRIG_PC_EN(trig_pc_en), .TRIG_PC(trig_pc), .TRIG_EXT(trig_ext),
        .RD_REQ(rd_req), .RD_ADDR(rd_addr), .RD_VALID(a_rd_valid), .RD_PC(a_rd_pc),
        .RD_WA(a_rd_wa), .RD_WD(a_rd_wd), .STATE(a_state), .DONE(a_done),
        .WRAPPED(a_wrapped), .TRIG_IDX(a_trig_idx), .COUNT(a_count)
    );

    riscv_trace_buf #(.AWIDTH(3), .DWIDTH(32), .POST_TRIG(0)) u_b (
        .CLK(clk), .RST(rst), .TR_EN(tr_en), .TR_PC(tr_pc), .TR_WA(tr_wa), .TR_WD(tr_wd),
        .ARM(arm), .TRIG_PC_EN(trig_pc_en), .TRIG_PC(trig_pc), .TRIG_EXT(trig_ext),
        .RD_REQ(rd_req), .RD_ADDR(rd_addr), .RD_VALID(b_rd_valid), .RD_PC(b_rd_pc),
        .RD_WA(b_rd_wa), .RD_WD(b_rd_wd), .STATE(b_state), .DONE(b_done),
        .WRAPPED(b_wrapped), .TRIG_IDX(b_trig_idx), .COUNT(b_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
        tr_en = 1'b1;
        tr_pc = pc;
        tr_wa = wa;
        tr_wd = wd;
        tick();
        tr_en = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic read_one(input logic [2:0] addr);
        rd_req  = 1'b1;
        rd_addr = addr;
        tick();
        rd_req  = 1'b0;
    endtask

    initial begin
        // Reset, then commits without ARM are ignored
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", a_state, 0);
        chk("rst_done", a_done, 0);
        chk("rst_wrapped", a_wrapped, 0);
        chk("rst_count", a_count, 0);
        chk("rst_trig_idx", a_trig_idx, 0);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_rd_pc", a_rd_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) commit(32'h40 + 4 * i, 5'd7, 32'hdead0000 + i);
        chk("idle_count", a_count, 0);
        chk("idle_state", a_state, 0);
        read_one(3'd0);
        chk("idle_rd_valid", a_rd_valid, 1);
        chk("idle_rd_pc", a_rd_pc, 0);
        chk("idle_rd_wa", a_rd_wa, 0);
        chk("idle_rd_wd", a_rd_wd, 0);
        tick();
        chk("idle_rd_valid_drop", a_rd_valid, 0);

        // PC-match trigger at 0x0C, two post-trigger entries
        arm_pulse();
        chk("arm_state", a_state, 1);
        trig_pc_en = 1'b1;
        trig_pc    = 32'h0C;
        for (int i = 0; i < 8; i++) begin
            commit(4 * i, 5'(i + 1), 32'h100 + i);
            if (i == 3) begin
                chk("pc_trig_state", a_state, 2);
                chk("pc_trig_idx", a_trig_idx, 3);
                chk("pc_trig_b_done", b_done, 1);
                chk("pc_trig_b_count", b_count, 4);
            end
            if (i == 4) chk("post_state", a_state, 2);
            if (i == 5) begin
                chk("post_done", a_done, 1);
                chk("post_count", a_count, 6);
            end
        end
        chk("frozen_count", a_count, 6);
        chk("frozen_state", a_state, 3);
        chk("frozen_b_count", b_count, 4);
        for (int k = 0; k < 6; k++) begin
            read_one(3'(k));
            chk("trace_pc", a_rd_pc, 4 * k);
            chk("trace_wa", a_rd_wa, k + 1);
            chk("trace_wd", a_rd_wd, 32'h100 + k);
        end
        read_one(3'd6);
        chk("beyond_valid", a_rd_valid, 1);
        chk("beyond_pc", a_rd_pc, 0);
        chk("beyond_wd", a_rd_wd, 0);

        // No trigger, 11 commits wrap the 8-entry buffer
        trig_pc_en = 1'b0;
        arm_pulse();
        for (int i = 1; i <= 11; i++) commit(32'h200 + 4 * i, 5'd3, i);
        chk("wrap_flag", a_wrapped, 1);
        chk("wrap_count", a_count, 8);
        chk("wrap_state", a_state, 1);
        rd_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            tick();
            chk("wrap_valid", a_rd_valid, 1);
            chk("wrap_wd", a_rd_wd, 4 + k);
            chk("wrap_pc", a_rd_pc, 32'h200 + 4 * (4 + k));
        end
        rd_req = 1'b0;
        tick();
        chk("wrap_valid_drop", a_rd_valid, 0);

        // External trigger with no commit at wptr=5
        arm_pulse();
        chk("rearm_wrapped", a_wrapped, 0);
        chk("rearm_count", a_count, 0);
        for (int i = 0; i < 5; i++) commit(32'h400 + 4 * i, 5'd9, i);
        trig_ext = 1'b1;
        tick();
        trig_ext = 1'b0;
        chk("ext_b_done", b_done, 1);
        chk("ext_b_trig_idx", b_trig_idx, 5);
        chk("ext_b_count", b_count, 5);
        chk("ext_a_state", a_state, 2);
        chk("ext_a_trig_idx", a_trig_idx, 5);
        commit(32'h414, 5'd9, 5);
        chk("ext_a_post1", a_state, 2);
        commit(32'h418, 5'd9, 6);
        chk("ext_a_done", a_done, 1);
        chk("ext_a_count", a_count, 7);
        commit(32'h41C, 5'd9, 7);
        chk("ext_a_count_frozen", a_count, 7);
        chk("ext_b_count_frozen", b_count, 5);
        read_one(3'd5);
        chk("ext_trig_entry_pc", a_rd_pc, 32'h414);

        // ARM and PC-match trigger in the same cycle
        trig_pc_en = 1'b1;
        trig_pc    = 32'h300;
        arm_pulse();
        commit(32'h300, 5'd1, 1);
        commit(32'h304, 5'd2, 2);
        chk("prio_pre_state", a_state, 2);
        chk("prio_pre_count", a_count, 2);
        arm = 1'b1;
        commit(32'h300, 5'd1, 1);
        arm = 1'b0;
        chk("prio_post_state", a_state, 1);
        chk("prio_post_count", a_count, 0);
        chk("prio_post_wrapped", a_wrapped, 0);
        arm = 1'b1;
        commit(32'h300, 5'd1, 1);
        arm = 1'b0;
        chk("prio_armed_a_state", a_state, 1);
        chk("prio_armed_b_state", b_state, 1);
        chk("prio_armed_b_count", b_count, 0);

        // Asynchronous reset during POST
        arm_pulse();
        commit(32'h2FC, 5'd4, 32'h44);
        commit(32'h300, 5'd5, 32'h55);
        chk("pre_rst_state", a_state, 2);
        chk("pre_rst_trig_idx", a_trig_idx, 1);
        read_one(3'd1);
        chk("pre_rst_rd_pc", a_rd_pc, 32'h300);
        #2;
        rst = 1'b1;
        #1;
        chk("async_state", a_state, 0);
        chk("async_done", a_done, 0);
        chk("async_count", a_count, 0);
        chk("async_wrapped", a_wrapped, 0);
        chk("async_trig_idx", a_trig_idx, 0);
        chk("async_rd_valid", a_rd_valid, 0);
        chk("async_rd_pc", a_rd_pc, 0);
        chk("async_rd_wd", a_rd_wd, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) commit(32'h300, 5'd6, i);
        chk("post_rst_count", a_count, 0);
        chk("post_rst_state", a_state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
